// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix stream loader.
// Build option: MATRIX_LOADER_BT_EN (B stream arrives column-major).
package matrix_pkg;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_FULL   = 2'd2
  } loader_state_t;

  localparam int DEF_AROWS     = 3;
  localparam int DEF_ACOLUMNS  = 3;
  localparam int DEF_BROWS     = 3;
  localparam int DEF_BCOLUMNS  = 3;
  localparam int DEF_WIDTH_BIT = 32;
  localparam int DEF_A_ELEMS   = DEF_AROWS * DEF_ACOLUMNS;
  localparam int DEF_B_ELEMS   = DEF_BROWS * DEF_BCOLUMNS;

  // Index width for a dimension of n entries (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// Row/column write-address counter for one matrix.
// COL_MAJOR=0: col is the fastest index; COL_MAJOR=1: row is the fastest index.
// Both counters wrap to (0,0) after the last element, so no out-of-range index is produced.
module matrix_rc_counter
  import matrix_pkg::*;
#(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inc,
  input  logic                        clr,
  output logic [idx_width(ROWS)-1:0]  row,
  output logic [idx_width(COLS)-1:0]  col,
  output logic                        last
);

  localparam int RW = idx_width(ROWS);
  localparam int CW = idx_width(COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic row_end;
  logic col_end;

  assign row_end = (row == ROW_MAX);
  assign col_end = (col == COL_MAX);
  assign last    = row_end && col_end;

  // Advance the element address on each accepted write; clr restarts at (0,0).
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (COL_MAJOR) begin
        row <= row_end ? '0 : row + RW'(1);
        if (row_end) col <= col_end ? '0 : col + CW'(1);
      end else begin
        col <= col_end ? '0 : col + CW'(1);
        if (col_end) row <= row_end ? '0 : row + RW'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// Fills registered A then B arrays from a serial element stream, then holds them
// (loaded=1) until release_i. Build option: MATRIX_LOADER_BT_EN makes the B stream
// column-major (B arrives transposed); A ordering and timing are unchanged.
//
// Handshake: an element transfers on a posedge where in_valid && in_ready. in_ready
// depends only on state and reset, never on in_valid; in_valid may drop at any time.
// flush beats a coincident handshake (element dropped) and a coincident release_i.
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int AROWS     = DEF_AROWS,
  parameter int ACOLUMNS  = DEF_ACOLUMNS,
  parameter int BROWS     = DEF_BROWS,
  parameter int BCOLUMNS  = DEF_BCOLUMNS,
  parameter int WIDTH_BIT = DEF_WIDTH_BIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH_BIT-1:0] in_data,
  output logic                 in_ready,
  input  logic                 release_i,
  input  logic                 flush,
  output logic [WIDTH_BIT-1:0] MatrixA [AROWS][ACOLUMNS],
  output logic [WIDTH_BIT-1:0] MatrixB [BROWS][BCOLUMNS],
  output logic                 loaded,
  output loader_state_t        debug_state
);

  if (ACOLUMNS != BROWS) begin : g_dim_check
    $error("matrix_stream_loader: ACOLUMNS must equal BROWS");
  end

`ifdef MATRIX_LOADER_BT_EN
  localparam bit B_COL_MAJOR = 1'b1;
`else
  localparam bit B_COL_MAJOR = 1'b0;
`endif

  loader_state_t state;

  logic [idx_width(AROWS)-1:0]    a_row;
  logic [idx_width(ACOLUMNS)-1:0] a_col;
  logic [idx_width(BROWS)-1:0]    b_row;
  logic [idx_width(BCOLUMNS)-1:0] b_col;
  logic a_last;
  logic b_last;
  logic accept;
  logic a_inc;
  logic b_inc;

  assign in_ready    = !reset && (state != S_FULL);
  assign loaded      = (state == S_FULL);
  assign debug_state = state;
  assign accept      = in_valid && in_ready && !flush;
  assign a_inc       = accept && (state == S_LOAD_A);
  assign b_inc       = accept && (state == S_LOAD_B);

  matrix_rc_counter #(.ROWS(AROWS), .COLS(ACOLUMNS), .COL_MAJOR(1'b0)) u_a_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (a_inc),
    .clr   (flush),
    .row   (a_row),
    .col   (a_col),
    .last  (a_last)
  );

  matrix_rc_counter #(.ROWS(BROWS), .COLS(BCOLUMNS), .COL_MAJOR(B_COL_MAJOR)) u_b_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (b_inc),
    .clr   (flush),
    .row   (b_row),
    .col   (b_col),
    .last  (b_last)
  );

  // Load sequencing: A, then B, then hold until released; flush restarts at A.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state <= S_LOAD_A;
    end else begin
      case (state)
        S_LOAD_A: if (a_inc && a_last) state <= S_LOAD_B;
        S_LOAD_B: if (b_inc && b_last) state <= S_FULL;
        S_FULL:   if (release_i)       state <= S_LOAD_A;
        default:                       state <= S_LOAD_A;
      endcase
    end
  end

  // Element storage: cleared only by reset, otherwise overwritten in place.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < AROWS; r++)
        for (int c = 0; c < ACOLUMNS; c++)
          MatrixA[r][c] <= '0;
      for (int r = 0; r < BROWS; r++)
        for (int c = 0; c < BCOLUMNS; c++)
          MatrixB[r][c] <= '0;
    end else begin
      if (a_inc) MatrixA[a_row][a_col] <= in_data;
      if (b_inc) MatrixB[b_row][b_col] <= in_data;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader (default 3x3, 32-bit).
// Honours MATRIX_LOADER_BT_EN for the expected B ordering.
module tb_matrix_stream_loader;
  import matrix_pkg::*;

  localparam int R = 3;
  localparam int C = 3;
  localparam int W = 32;
  localparam int NA = R * C;
  localparam int NT = 2 * R * C;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         release_i;
  logic         flush;
  logic [W-1:0] MatrixA [R][C];
  logic [W-1:0] MatrixB [R][C];
  logic         loaded;
  loader_state_t debug_state;

  matrix_stream_loader dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .release_i   (release_i),
    .flush       (flush),
    .MatrixA     (MatrixA),
    .MatrixB     (MatrixB),
    .loaded      (loaded),
    .debug_state (debug_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Loader seen as: element counter n over A then B, plus a "full" flag.
  logic [W-1:0] ma [R][C];
  logic [W-1:0] mb [R][C];
  int           m_n;
  bit           m_full;
  logic [W-1:0] exp_q [$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 0;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void place(input int k, input logic [W-1:0] d);
    int j;
    if (k < NA) begin
      ma[k / C][k % C] = d;
    end else begin
      j = k - NA;
`ifdef MATRIX_LOADER_BT_EN
      mb[j % R][j / R] = d;
`else
      mb[j / C][j % C] = d;
`endif
    end
  endfunction

  function automatic void model_step(input logic v, input logic [W-1:0] d,
                                     input logic rel, input logic fl, input logic rst);
    if (rst) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          ma[r][c] = '0;
          mb[r][c] = '0;
        end
      m_n = 0;
      m_full = 0;
    end else if (fl) begin
      m_n = 0;
      m_full = 0;
    end else if (m_full) begin
      if (rel) m_full = 0;
    end else if (v) begin
      place(m_n, d);
      m_n++;
      if (m_n == NT) begin
        m_n = 0;
        m_full = 1;
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++) exp_q.push_back(ma[r][c]);
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++) exp_q.push_back(mb[r][c]);
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [W-1:0] d,
                       input logic rel, input logic fl, input logic rst);
    in_valid  = v;
    in_data   = d;
    release_i = rel;
    flush     = fl;
    reset     = rst;
    @(posedge clock);
    model_step(v, d, rel, fl, rst);
    #1;
  endtask

  task automatic stream(input int first, input int count, input bit toggle);
    int k;
    k = 0;
    while (k < count) begin
      if (toggle && (k % 2 == 1)) begin
        cycle(1'b0, 32'hdead_0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, W'(first + k), 1'b0, 1'b0, 1'b0);
      end else begin
        cycle(1'b1, W'(first + k), 1'b0, 1'b0, 1'b0);
      end
      k++;
    end
    in_valid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_loaded = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      int diffs;
      check("in_ready", in_ready, (!reset && !m_full) ? 1 : 0);
      check("loaded", loaded, m_full ? 1 : 0);
      diffs = 0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          if (MatrixA[r][c] !== ma[r][c] || MatrixB[r][c] !== mb[r][c]) begin
            if (diffs == 0)
              $display("FAIL arrays[%0d][%0d]: A=%0h B=%0h expected A=%0h B=%0h at %0t",
                       r, c, MatrixA[r][c], MatrixB[r][c], ma[r][c], mb[r][c], $time);
            diffs++;
          end
        end
      total++;
      if (diffs != 0) bad++;
      if (loaded === 1'b1 && prev_loaded !== 1'b1) begin
        if (exp_q.size() < NT) begin
          total++;
          bad++;
          $display("FAIL snapshot: loaded rose with %0d expected elements queued, required %0d",
                   exp_q.size(), NT);
        end else begin
          for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) check("snap_a", MatrixA[r][c], exp_q.pop_front());
          for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) check("snap_b", MatrixB[r][c], exp_q.pop_front());
        end
      end
      prev_loaded <= loaded;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_valid = 0; in_data = 0; release_i = 0; flush = 0; reset = 1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    mon_en = 1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("reset_a00", MatrixA[0][0], 0);
    check("reset_loaded", loaded, 0);
    check("reset_ready", in_ready, 1);

    // 1: full load with in_valid held high
    stream(1, 17, 0);
    check("pre_loaded", loaded, 0);
    stream(18, 1, 0);
    check("t1_loaded", loaded, 1);
    check("t1_a00", MatrixA[0][0], 1);
    check("t1_a02", MatrixA[0][2], 3);
    check("t1_a22", MatrixA[2][2], 9);
    check("t1_b00", MatrixB[0][0], 10);
    check("t1_b22", MatrixB[2][2], 18);
`ifdef MATRIX_LOADER_BT_EN
    check("bt_b10", MatrixB[1][0], 11);
    check("bt_b01", MatrixB[0][1], 13);
`else
    check("rm_b01", MatrixB[0][1], 11);
    check("rm_b10", MatrixB[1][0], 13);
`endif

    // 2: same data, in_valid toggling
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    stream(1, 18, 1);
    check("t2_loaded", loaded, 1);
    check("t2_a21", MatrixA[2][1], 8);

    // 3: held while full, then release and reload
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'd99, 1'b0, 1'b0, 1'b0);
    check("t3_ready_full", in_ready, 0);
    check("t3_a00_frozen", MatrixA[0][0], 1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t3_loaded_rel", loaded, 0);
    check("t3_ready_rel", in_ready, 1);
    stream(20, 18, 0);
    check("t3_a00", MatrixA[0][0], 20);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 4: flush coincident with the 6th A handshake
    stream(1, 5, 0);
    cycle(1'b1, 32'd6, 1'b0, 1'b1, 1'b0);
    check("t4_a12_kept", MatrixA[1][2], 25);
    stream(7, 1, 0);
    check("t4_a00", MatrixA[0][0], 7);

    // 5: reset after 4 elements of a fresh load
    stream(8, 3, 0);
    cycle(1'b1, 32'd11, 1'b0, 1'b0, 1'b1);
    check("t5_ready_rst", in_ready, 0);
    check("t5_a00", MatrixA[0][0], 0);
    check("t5_loaded", loaded, 0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t5_ready_after", in_ready, 1);

    // flush together with release while full
    stream(40, 18, 0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("fl_rel_loaded", loaded, 0);

    // random traffic with occasional release and flush
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 60) == 0), 1'b0);

    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
